// File: rtl/button_press_decoder_if.sv
// Button gesture bus: debounced level in, gesture pulses and held level out.
// The master drives the button level; the slave (decoder) drives the results.
interface button_press_decoder_if;
  logic in;
  logic short_press;
  logic long_press;
  logic double_press;
  logic held;

  modport master (
    output in,
    input  short_press,
    input  long_press,
    input  double_press,
    input  held
  );

  modport slave (
    input  in,
    output short_press,
    output long_press,
    output double_press,
    output held
  );
endinterface

// File: rtl/button_press_decoder.sv
// Classifies debounced button presses into short/long/double pulses plus a held level.
// Optional auto-repeat of long_press while held is enabled by defining BUTTON_REPEAT_EN.
module button_press_decoder #(
  parameter int                    COUNT_SIZE   = 24,
  parameter logic [COUNT_SIZE-1:0] LONG_LIMIT   = 24'd6000000,
  parameter logic [COUNT_SIZE-1:0] DOUBLE_LIMIT = 24'd3000000,
  parameter logic [COUNT_SIZE-1:0] REPEAT_LIMIT = 24'd1200000
) (
  input logic                    clock,
  input logic                    reset,
  button_press_decoder_if.slave  bus
);

  // A timeout fires on the edge ending the cycle where the counter reads LIMIT-1.
  localparam logic [COUNT_SIZE-1:0] LONG_LAST   = LONG_LIMIT   - COUNT_SIZE'(1);
  localparam logic [COUNT_SIZE-1:0] DOUBLE_LAST = DOUBLE_LIMIT - COUNT_SIZE'(1);
  localparam logic [COUNT_SIZE-1:0] REPEAT_LAST = REPEAT_LIMIT - COUNT_SIZE'(1);

`ifdef BUTTON_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    WAIT_SECOND,
    SECOND_PRESSED,
    HELD
  } state_e;

  state_e                  state_q;
  logic [COUNT_SIZE-1:0]   cnt_q;
  logic [COUNT_SIZE-1:0]   cnt_d;
  logic                    short_q;
  logic                    long_q;
  logic                    double_q;
  logic                    held_q;

  assign cnt_d = cnt_q + COUNT_SIZE'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (bus.in) state_q <= PRESSED;
        end
        // Release is checked before the timeout so it wins on the same edge.
        PRESSED: begin
          if (!bus.in) begin
            state_q <= WAIT_SECOND;
            cnt_q   <= '0;
          end else if (cnt_q == LONG_LAST) begin
            state_q <= HELD;
            cnt_q   <= '0;
            long_q  <= 1'b1;
            held_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WAIT_SECOND: begin
          if (bus.in) begin
            state_q  <= SECOND_PRESSED;
            cnt_q    <= '0;
            double_q <= 1'b1;
          end else if (cnt_q == DOUBLE_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            short_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        SECOND_PRESSED: begin
          cnt_q <= '0;
          if (!bus.in) state_q <= IDLE;
        end
        HELD: begin
          if (!bus.in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
          end else if (REPEAT_ON) begin
            if (cnt_q == REPEAT_LAST) begin
              long_q <= 1'b1;
              cnt_q  <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end else begin
            cnt_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.short_press  = short_q;
  assign bus.long_press   = long_q;
  assign bus.double_press = double_q;
  assign bus.held         = held_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// Scoreboard bench for button_press_decoder: expected pulses are queued with their cycle.
// A negedge monitor pops and compares each pulse the decoder produces.
module tb_button_press_decoder;

  localparam int LONG = 8;
  localparam int DBL  = 6;
  localparam int REP  = 4;

  localparam int K_SHORT  = 0;
  localparam int K_LONG   = 1;
  localparam int K_DOUBLE = 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clock;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  ev_t  exp_q[$];

  button_press_decoder_if bif ();

  button_press_decoder #(
    .COUNT_SIZE   (8),
    .LONG_LIMIT   (8'(LONG)),
    .DOUBLE_LIMIT (8'(DBL)),
    .REPEAT_LIMIT (8'(REP))
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Pulse monitor: every observed pulse must match the head of the expected queue.
  always @(negedge clock) begin : monitor
    int  n;
    int  k;
    ev_t e;
    n = int'(bif.short_press) + int'(bif.long_press) + int'(bif.double_press);
    if (n > 1) begin
      checks++;
      errors++;
      $display("FAIL overlap: %0d pulses high at cyc %0d, required at most 1", n, cyc);
    end
    if (n > 0) begin
      k = bif.short_press ? K_SHORT : (bif.long_press ? K_LONG : K_DOUBLE);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: kind %0d at cyc %0d, required none", k, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.kind !== k || e.cyc !== cyc) begin
          errors++;
          $display("FAIL pulse: kind %0d at cyc %0d, required kind %0d at cyc %0d",
                   k, cyc, e.kind, e.cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    bif.in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if ({bif.short_press, bif.long_press, bif.double_press, bif.held} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs: %b, required 0000",
                 {bif.short_press, bif.long_press, bif.double_press, bif.held});
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      checks++;
      if (bif.held !== 1'b0) begin
        errors++;
        $display("FAIL idle_held: %b at cyc %0d, required 0", bif.held, cyc);
      end
    end
  endtask

  task automatic test_short();
    int r;
    bif.in = 1'b1;
    step(3);
    bif.in = 1'b0;
    r = cyc + 1;
    exp_q.push_back('{K_SHORT, r + DBL});
    for (int i = 0; i < 20; i++) begin
      step(1);
      checks++;
      if (bif.held !== 1'b0) begin
        errors++;
        $display("FAIL short_held: %b at cyc %0d, required 0", bif.held, cyc);
      end
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL short_missing: %0d pulses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_long();
    int p;
    int r;
    bit exp_h;
    bif.in = 1'b1;
    p = cyc + 1;
    r = p + 20;
    exp_q.push_back('{K_LONG, p + LONG});
`ifdef BUTTON_REPEAT_EN
    for (int t = p + LONG + REP; t < r; t += REP) exp_q.push_back('{K_LONG, t});
`endif
    for (int i = 0; i < 26; i++) begin
      if (cyc + 1 == r) bif.in = 1'b0;
      step(1);
      exp_h = (cyc >= p + LONG) && (cyc < r);
      checks++;
      if (bif.held !== exp_h) begin
        errors++;
        $display("FAIL long_held: %b at cyc %0d, required %b", bif.held, cyc, exp_h);
      end
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL long_missing: %0d pulses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_double();
    bif.in = 1'b1;
    step(3);
    bif.in = 1'b0;
    step(2);
    bif.in = 1'b1;
    exp_q.push_back('{K_DOUBLE, cyc + 1});
    step(3);
    bif.in = 1'b0;
    step(20);
    checks++;
    if (exp_q.size() !== 0 || bif.held !== 1'b0) begin
      errors++;
      $display("FAIL double: outstanding %0d held %b, required 0 and 0", exp_q.size(), bif.held);
    end
  endtask

  task automatic test_double_boundary();
    int r;
    bif.in = 1'b1;
    step(3);
    bif.in = 1'b0;
    r = cyc + 1;
    step(DBL);
    bif.in = 1'b1;
    checks++;
    if (cyc + 1 !== r + DBL) begin
      errors++;
      $display("FAIL double_edge_setup: press edge %0d, required %0d", cyc + 1, r + DBL);
    end
    exp_q.push_back('{K_DOUBLE, r + DBL});
    step(3);
    bif.in = 1'b0;
    step(20);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL double_edge_missing: %0d pulses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_long_boundary();
    int p;
    bif.in = 1'b1;
    p = cyc + 1;
    step(LONG);
    bif.in = 1'b0;
    exp_q.push_back('{K_SHORT, p + LONG + DBL});
    for (int i = 0; i < 25; i++) begin
      step(1);
      checks++;
      if (bif.held !== 1'b0) begin
        errors++;
        $display("FAIL long_edge_held: %b at cyc %0d, required 0", bif.held, cyc);
      end
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL long_edge_missing: %0d pulses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int  p;
    bit  exp_h;
    bif.in = 1'b1;
    step(4);
    reset = 1'b0;
    #1;
    checks++;
    if ({bif.short_press, bif.long_press, bif.double_press, bif.held} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_outputs: %b, required 0000",
               {bif.short_press, bif.long_press, bif.double_press, bif.held});
    end
    step(1);
    reset = 1'b1;
    p = cyc + 1;
    exp_q.push_back('{K_LONG, p + LONG});
    for (int i = 0; i < 12; i++) begin
      step(1);
      exp_h = (cyc >= p + LONG);
      checks++;
      if (bif.held !== exp_h) begin
        errors++;
        $display("FAIL restart_held: %b at cyc %0d, required %b", bif.held, cyc, exp_h);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bif.held !== 1'b0) begin
      errors++;
      $display("FAIL held_async_reset: %b, required 0", bif.held);
    end
    step(1);
    bif.in = 1'b0;
    reset  = 1'b1;
    step(10);
    checks++;
    if (exp_q.size() !== 0 || bif.held !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_end: outstanding %0d held %b, required 0 and 0",
               exp_q.size(), bif.held);
    end
  endtask

  initial begin
    cyc    = 0;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bif.in = 1'b0;
    #1;
    test_reset();
    test_short();
    test_long();
    test_double();
    test_double_boundary();
    test_long_boundary();
    test_reset_mid();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL final_queue: %0d pulses outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
